aes_sbox_pipe: RTL

//   Multi-lane pipelined AES byte-substitution engine. Applies the forward S-box
//   (encrypt) or inverse S-box (decrypt) to LANES bytes per beat, selected per beat.

---
 rtl/aes_sbox_pipe.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_sbox_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_pipe (with aes_sbox, aes_inv_sbox, aes_sbox_pkg)
// Description : Multi-lane pipelined AES byte substitution. Each beat carries
//               LANES bytes and a per-beat mode bit selecting the forward
//               S-box or the inverse S-box. Valid/ready on both sides,
//               one beat per cycle sustained, 1 or 2 register stages.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// GF(2^8) arithmetic behind the Rijndael S-box. The tables are not stored;
// they are the multiplicative inverse modulo x^8+x^4+x^3+x+1 combined with
// the Rijndael affine map (or its inverse), which synthesis flattens to logic.
// ----------------------------------------------------------------------------
package aes_sbox_pkg;

  // Multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiplication in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end
      aa = gf_xtime(aa);
    end
    return acc;
  endfunction

  // Inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = gf_mul(x, x);
    r = p;
    for (int i = 2; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine map b ^ rotl1..4(b) ^ 0x63.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine map rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then inverse.
  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// ----------------------------------------------------------------------------
// Single-byte forward S-box lane.
// ----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  assign o_byte = aes_sbox_pkg::sbox_fwd(i_byte);
endmodule

// ----------------------------------------------------------------------------
// Single-byte inverse S-box lane.
// ----------------------------------------------------------------------------
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  assign o_byte = aes_sbox_pkg::sbox_inv(i_byte);
endmodule

// ----------------------------------------------------------------------------
// Pipelined multi-lane substitution engine.
// ----------------------------------------------------------------------------
module aes_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int PIPE   = 1,
  parameter int INV_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_inv,
  output logic [8*LANES-1:0]   out_data,
  output logic                 idle
);

  localparam int W = 8 * LANES;

  logic         w_mode;    // effective mode: forced forward when no inverse lanes
  logic [W-1:0] w_sub;     // combinational substitution of in_data
  logic         w_in_rdy;  // stage 1 can take a beat this cycle
  logic         w_acc;     // input-side transfer

  assign w_mode   = in_inv & (INV_EN != 0);
  assign w_acc    = in_valid & w_in_rdy;
  assign in_ready = w_in_rdy;

  // Per-lane lookup; lanes are independent and keep their byte position.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] w_fwd;
      aes_sbox u_fwd (
        .i_byte (in_data[8*gi +: 8]),
        .o_byte (w_fwd)
      );
      if (INV_EN != 0) begin : g_inv
        logic [7:0] w_inv;
        aes_inv_sbox u_inv (
          .i_byte (in_data[8*gi +: 8]),
          .o_byte (w_inv)
        );
        assign w_sub[8*gi +: 8] = w_mode ? w_inv : w_fwd;
      end else begin : g_fwd_only
        assign w_sub[8*gi +: 8] = w_fwd;
      end
    end
  endgenerate

  // Register stages. A stage loads when empty or when its content leaves in
  // the same cycle; otherwise it holds. out_ready reaches in_ready through
  // the advance term, but in_valid never reaches out_valid combinationally.
  generate
    if (PIPE >= 2) begin : g_pipe2
      logic         r_v1;
      logic         r_i1;
      logic [W-1:0] r_d1;
      logic         r_v2;
      logic         r_i2;
      logic [W-1:0] r_d2;
      logic         w_s2_open;  // stage 2 empty or draining this cycle
      logic         w_adv1;     // stage 1 content moves to stage 2

      assign w_s2_open = ~r_v2 | out_ready;
      assign w_adv1    = r_v1 & w_s2_open;
      assign w_in_rdy  = ~r_v1 | w_adv1;

      // Stage 1 occupancy follows in_valid whenever stage 1 is free to load.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v1 <= 1'b0;
        end else if (w_in_rdy) begin
          r_v1 <= in_valid;
        end
      end

      // Stage 1 payload captures the lookup result only on acceptance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d1 <= '0;
          r_i1 <= 1'b0;
        end else if (w_acc) begin
          r_d1 <= w_sub;
          r_i1 <= w_mode;
        end
      end

      // Stage 2 occupancy follows stage 1 whenever stage 2 is free to load.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
        end else if (w_s2_open) begin
          r_v2 <= r_v1;
        end
      end

      // Stage 2 payload moves only when a valid beat advances out of stage 1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d2 <= '0;
          r_i2 <= 1'b0;
        end else if (w_adv1) begin
          r_d2 <= r_d1;
          r_i2 <= r_i1;
        end
      end

      assign out_valid = r_v2;
      assign out_data  = r_d2;
      assign out_inv   = r_i2;
      assign idle      = ~(r_v1 | r_v2);
    end else begin : g_pipe1
      logic         r_v1;
      logic         r_i1;
      logic [W-1:0] r_d1;

      assign w_in_rdy = ~r_v1 | out_ready;

      // Single stage occupancy follows in_valid whenever it is free to load.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v1 <= 1'b0;
        end else if (w_in_rdy) begin
          r_v1 <= in_valid;
        end
      end

      // Single stage payload captures the lookup result only on acceptance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d1 <= '0;
          r_i1 <= 1'b0;
        end else if (w_acc) begin
          r_d1 <= w_sub;
          r_i1 <= w_mode;
        end
      end

      assign out_valid = r_v1;
      assign out_data  = r_d1;
      assign out_inv   = r_i1;
      assign idle      = ~r_v1;
    end
  endgenerate

endmodule
`default_nettype wire
